// File: rtl/trace_pkg.sv
// Shared trace-entry layout, FSM encoding and entry packing for the retire trace buffer.
// Pure declarations: no latency, no flow control.
package trace_pkg;

    localparam int TRACE_W   = 103;
    localparam int HALT_BIT  = 0;
    localparam int TRAP_BIT  = 1;
    localparam int WDATA_LSB = 2;
    localparam int WADDR_LSB = 34;
    localparam int INST_LSB  = 39;
    localparam int PC_LSB    = 71;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Write data is meaningless without a destination, so x0 writes are zeroed.
    function automatic logic [TRACE_W-1:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic [4:0]  rd_waddr,
        input logic [31:0] rd_wdata,
        input logic        trap,
        input logic        halt
    );
        return {pc, inst, rd_waddr, (rd_waddr == 5'd0) ? 32'd0 : rd_wdata, trap, halt};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; write visible one cycle later, head is zero when empty.
// Writes into a full FIFO are ignored unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_FULL);
    assign rd_ok   = i_rd_en & ~o_empty;
    assign wr_ok   = i_wr_en & (~o_full | rd_ok);
    assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Buffers retired instructions for a trace sink; retire at edge N is visible at the head after N.
// Sink backpressure never stalls the hart: retires arriving at a full FIFO are counted and dropped.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_retire_valid,
    input  logic [31:0]      i_retire_inst,
    input  logic             i_retire_trap,
    input  logic             i_retire_halt,
    input  logic [31:0]      i_retire_pc,
    input  logic [4:0]       i_retire_rd_waddr,
    input  logic [31:0]      i_retire_rd_wdata,
    output logic             o_trace_valid,
    input  logic             i_trace_ready,
    output logic [31:0]      o_trace_pc,
    output logic [31:0]      o_trace_inst,
    output logic [4:0]       o_trace_rd_waddr,
    output logic [31:0]      o_trace_rd_wdata,
    output logic             o_trace_trap,
    output logic             o_trace_halt,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instret_count,
    output logic [CNT_W-1:0] o_drop_count,
    output logic             o_overflow,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    state_e             state_q;
    logic               done_q;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               overflow_q, overflow_d;
    logic               in_run, push, pop, drop;
    logic               fifo_empty, fifo_full;
    logic [TRACE_W-1:0] head;

    assign in_run = (state_q == ST_RUN);
    assign push   = in_run & i_retire_valid;
    assign pop    = o_trace_valid & i_trace_ready;
    assign drop   = push & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (push),
        .i_wr_data (pack_entry(i_retire_pc, i_retire_inst, i_retire_rd_waddr,
                               i_retire_rd_wdata, i_retire_trap, i_retire_halt)),
        .i_rd_en   (pop),
        .o_rd_data (head),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

    assign o_trace_valid    = ~fifo_empty;
    assign o_trace_pc       = head[PC_LSB    +: 32];
    assign o_trace_inst     = head[INST_LSB  +: 32];
    assign o_trace_rd_waddr = head[WADDR_LSB +: 5];
    assign o_trace_rd_wdata = head[WDATA_LSB +: 32];
    assign o_trace_trap     = head[TRAP_BIT];
    assign o_trace_halt     = head[HALT_BIT];

    always_comb begin
        cycle_d    = cycle_q;
        instret_d  = instret_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        if (in_run) begin
            cycle_d = sat_inc(cycle_q);
            if (i_retire_valid) instret_d = sat_inc(instret_q);
            if (drop) begin
                drop_d     = sat_inc(drop_q);
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_q    <= '0;
            instret_q  <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    // The halt retire moves to DRAIN even when its own entry was dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_retire_valid & i_retire_halt) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: done_q <= 1'b1;
                default: begin
                    state_q <= ST_RUN;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cycle_count   = cycle_q;
    assign o_instret_count = instret_q;
    assign o_drop_count    = drop_q;
    assign o_overflow      = overflow_q;
    assign o_done          = done_q;

endmodule
